// File: rtl/decimal_entry_peripheral.sv
// Decimal key-entry peripheral: debounced pushbuttons build a signed 32-bit value handed to the CPU via valid/ack.
// Optional live view of the entry in progress is enabled with `define LIVE_VIEW_EN.
module decimal_entry_peripheral #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit_sw,
  input  logic        key_digit_n,
  input  logic        key_sign_n,
  input  logic        key_enter_n,
  input  logic        key_clear_n,
  input  logic        rd_ack,
  output logic [31:0] dout,
  output logic        valid,
  output logic        overflow,
  output logic [3:0]  digit_count
`ifdef LIVE_VIEW_EN
  ,
  output logic [31:0] live_value
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int NK = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  typedef enum logic {S_IDLE = 1'b0, S_CALC = 1'b1} state_t;

  logic [NK-1:0] key_raw_n;
  logic [NK-1:0] key_evt;

  assign key_raw_n = {key_clear_n, key_enter_n, key_sign_n, key_digit_n};

  generate
    for (genvar gi = 0; gi < NK; gi++) begin : g_key
      logic          sync1_q, sync2_q;
      logic          stable_q, stable_d;
      logic          evt_q, evt_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // Counter only runs while the synced level disagrees with the accepted one.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
          if (cnt_q == CNT_LAST) stable_d = sync2_q;
          else                   cnt_d    = cnt_q + 1'b1;
        end
        evt_d = stable_q & ~stable_d;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q  <= 1'b1;
          sync2_q  <= 1'b1;
          stable_q <= 1'b1;
          cnt_q    <= '0;
          evt_q    <= 1'b0;
        end else begin
          sync1_q  <= key_raw_n[gi];
          sync2_q  <= sync1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
          evt_q    <= evt_d;
        end
      end

      assign key_evt[gi] = evt_q;
    end
  endgenerate

  logic ev_clear, ev_enter, ev_sign, ev_digit;
  assign ev_clear = key_evt[3];
  assign ev_enter = key_evt[2] & ~key_evt[3];
  assign ev_sign  = key_evt[1] & ~key_evt[2] & ~key_evt[3];
  assign ev_digit = key_evt[0] & ~key_evt[1] & ~key_evt[2] & ~key_evt[3];

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [3:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  digit_q, digit_d;
  logic [31:0] dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic [35:0] cand;
  logic [35:0] limit;
  logic [31:0] signed_val;

  assign cand       = ({4'b0, mag_q} << 3) + ({4'b0, mag_q} << 1) + {32'b0, digit_q};
  assign limit      = neg_q ? 36'd2147483648 : 36'd2147483647;
  assign signed_val = neg_q ? (~mag_q + 32'd1) : mag_q;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    digit_d = digit_q;
    dout_d  = dout_q;
    pend_d  = 1'b0;
    valid_d = valid_q & ~rd_ack;
    case (state_q)
      S_IDLE: begin
        if (ev_clear) begin
          mag_d   = '0;
          neg_d   = 1'b0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (ev_enter || pend_q) begin
          dout_d  = signed_val;
          valid_d = 1'b1;
          mag_d   = '0;
          neg_d   = 1'b0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (ev_sign) begin
          neg_d = ~neg_q;
        end else if (ev_digit && (digit_sw <= 4'd9) && (count_q < MAX_CNT)) begin
          digit_d = digit_sw;
          state_d = S_CALC;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (ev_clear) begin
          mag_d   = '0;
          neg_d   = 1'b0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          if (cand > limit) begin
            ovf_d = 1'b1;
          end else begin
            mag_d   = cand[31:0];
            count_d = count_q + 1'b1;
            ovf_d   = 1'b0;
          end
          // An enter landing here commits next cycle so this digit is included.
          pend_d = ev_enter;
          if (ev_sign) neg_d = ~neg_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      digit_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      digit_q <= digit_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign dout        = dout_q;
  assign valid       = valid_q;
  assign overflow    = ovf_q;
  assign digit_count = count_q;

`ifdef LIVE_VIEW_EN
  logic [31:0] live_q, live_d;
  assign live_d = signed_val;

  always_ff @(posedge clk) begin
    if (reset) live_q <= '0;
    else       live_q <= live_d;
  end

  assign live_value = live_q;
`endif

endmodule

// File: tb/tb_decimal_entry_peripheral.sv
// Self-checking bench for decimal_entry_peripheral: table of key operations with a scoreboard queue,
// followed by hand-written bounce, coincident-key and reset-in-CALC sequences.
module tb_decimal_entry_peripheral;

  typedef enum int {OP_DIG, OP_SIGN, OP_ENT, OP_CLR, OP_ACK} op_t;

  typedef struct {
    op_t         op;
    logic [3:0]  sw;
    logic [3:0]  cnt;
    logic        ovf;
    logic        vld;
    logic [31:0] dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit_sw = 4'd0;
  logic [3:0]  key_n = 4'b1111;
  logic        rd_ack = 1'b0;
  logic [31:0] dout;
  logic        valid;
  logic        overflow;
  logic [3:0]  digit_count;
`ifdef LIVE_VIEW_EN
  logic [31:0] live_value;
`endif

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  decimal_entry_peripheral #(
    .DEBOUNCE_CYCLES(4),
    .MAX_DIGITS(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .digit_sw(digit_sw),
    .key_digit_n(key_n[0]),
    .key_sign_n(key_n[1]),
    .key_enter_n(key_n[2]),
    .key_clear_n(key_n[3]),
    .rd_ack(rd_ack),
    .dout(dout),
    .valid(valid),
    .overflow(overflow),
    .digit_count(digit_count)
`ifdef LIVE_VIEW_EN
    ,
    .live_value(live_value)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input op_t op, input logic [3:0] sw, input logic [3:0] cnt,
                     input logic ovf, input logic vld, input logic [31:0] d);
    vec_t v;
    v.op = op; v.sw = sw; v.cnt = cnt; v.ovf = ovf; v.vld = vld; v.dout = d;
    tbl.push_back(v);
  endtask

  // Hold keys down long enough to debounce, then release and let the release debounce too.
  task automatic press(input logic [3:0] mask, input logic [3:0] sw);
    @(negedge clk);
    digit_sw = sw;
    key_n = ~mask;
    repeat (8) @(negedge clk);
    key_n = 4'b1111;
    repeat (10) @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check("valid_after_ack", {31'b0, valid}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic add_digits(input int digits[], input logic [31:0] d, input int start_cnt);
    for (int i = 0; i < digits.size(); i++)
      add(OP_DIG, 4'(digits[i]), 4'(start_cnt + i + 1), 1'b0, 1'b0, d);
  endtask

  initial begin
    vec_t exp_v;
    vec_t cur;
    int   waited;
    int   d_max[] = '{2, 1, 4, 7, 4, 8, 3, 6, 4, 7};
    int   d_min[] = '{2, 1, 4, 7, 4, 8, 3, 6, 4, 8};
    int   d_nine[] = '{2, 1, 4, 7, 4, 8, 3, 6, 4};

    // Entry 123, then read it.
    add(OP_DIG, 4'd1, 4'd1, 0, 0, 32'd0);
    add(OP_DIG, 4'd2, 4'd2, 0, 0, 32'd0);
    add(OP_DIG, 4'd3, 4'd3, 0, 0, 32'd0);
    add(OP_ENT, 4'd0, 4'd0, 0, 1, 32'd123);
    add(OP_ACK, 4'd0, 4'd0, 0, 0, 32'd123);
    // -50, then sign alone must commit plain zero.
    add(OP_DIG, 4'd5, 4'd1, 0, 0, 32'd123);
    add(OP_DIG, 4'd0, 4'd2, 0, 0, 32'd123);
    add(OP_SIGN, 4'd0, 4'd2, 0, 0, 32'd123);
    add(OP_ENT, 4'd0, 4'd0, 0, 1, 32'hFFFF_FFCE);
    add(OP_ACK, 4'd0, 4'd0, 0, 0, 32'hFFFF_FFCE);
    add(OP_SIGN, 4'd0, 4'd0, 0, 0, 32'hFFFF_FFCE);
    add(OP_ENT, 4'd0, 4'd0, 0, 1, 32'd0);
    add(OP_ACK, 4'd0, 4'd0, 0, 0, 32'd0);
    add(OP_DIG, 4'hA, 4'd0, 0, 0, 32'd0);
    // Largest positive, non-BCD and 11th digit ignored, clear leaves valid/dout alone.
    add_digits(d_max, 32'd0, 0);
    add(OP_DIG, 4'hA, 4'd10, 0, 0, 32'd0);
    add(OP_DIG, 4'd5, 4'd10, 0, 0, 32'd0);
    add(OP_ENT, 4'd0, 4'd0, 0, 1, 32'h7FFF_FFFF);
    add(OP_CLR, 4'd0, 4'd0, 0, 1, 32'h7FFF_FFFF);
    add(OP_ACK, 4'd0, 4'd0, 0, 0, 32'h7FFF_FFFF);
    // Most negative value.
    add(OP_SIGN, 4'd0, 4'd0, 0, 0, 32'h7FFF_FFFF);
    add_digits(d_min, 32'h7FFF_FFFF, 0);
    add(OP_ENT, 4'd0, 4'd0, 0, 1, 32'h8000_0000);
    add(OP_ACK, 4'd0, 4'd0, 0, 0, 32'h8000_0000);
    // Positive overflow on the 10th digit.
    add_digits(d_nine, 32'h8000_0000, 0);
    add(OP_DIG, 4'd8, 4'd9, 1, 0, 32'h8000_0000);
    add(OP_ENT, 4'd0, 4'd0, 0, 1, 32'd214748364);
    add(OP_ACK, 4'd0, 4'd0, 0, 0, 32'd214748364);
    // Second enter while valid overwrites.
    add(OP_DIG, 4'd7, 4'd1, 0, 0, 32'd214748364);
    add(OP_ENT, 4'd0, 4'd0, 0, 1, 32'd7);
    add(OP_DIG, 4'd9, 4'd1, 0, 1, 32'd7);
    add(OP_ENT, 4'd0, 4'd0, 0, 1, 32'd9);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_dout", dout, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_overflow", {31'b0, overflow}, 32'd0);
    check("reset_count", {28'b0, digit_count}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      cur = tbl[i];
      sb.push_back(cur);
      case (cur.op)
        OP_DIG:  press(4'b0001, cur.sw);
        OP_SIGN: press(4'b0010, cur.sw);
        OP_ENT:  press(4'b0100, cur.sw);
        OP_CLR:  press(4'b1000, cur.sw);
        default: ack_pulse();
      endcase
      exp_v = sb.pop_front();
      $display("txn %0d op=%0d sw=%0h count=%0d ovf=%0b valid=%0b dout=0x%08h",
               i, cur.op, cur.sw, digit_count, overflow, valid, dout);
      check($sformatf("t%0d_count", i), {28'b0, digit_count}, {28'b0, exp_v.cnt});
      check($sformatf("t%0d_overflow", i), {31'b0, overflow}, {31'b0, exp_v.ovf});
      check($sformatf("t%0d_valid", i), {31'b0, valid}, {31'b0, exp_v.vld});
      check($sformatf("t%0d_dout", i), dout, exp_v.dout);
    end

    // Short bounces must never register.
    digit_sw = 4'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); key_n[0] = 1'b0;
      repeat (2) @(negedge clk); key_n[0] = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (15) @(negedge clk);
    $display("txn bounce count=%0d", digit_count);
    check("bounce_count", {28'b0, digit_count}, 32'd0);

    // Digit and clear debounced in the same cycle: clear wins.
    press(4'b0001, 4'd3);
    check("pre_coinc_count", {28'b0, digit_count}, 32'd1);
    press(4'b1001, 4'd6);
    $display("txn coincident count=%0d dout=0x%08h", digit_count, dout);
    check("coinc_count", {28'b0, digit_count}, 32'd0);
    check("coinc_valid", {31'b0, valid}, 32'd1);
    check("coinc_dout", dout, 32'd9);

    // Reset while the digit FSM is computing.
    @(negedge clk);
    digit_sw = 4'd6;
    key_n[0] = 1'b0;
    waited = 0;
    while (int'(dut.state_q) != 1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("calc_reached", {31'b0, (waited < 40)}, 32'd1);
    reset = 1'b1;
    key_n[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset_in_calc count=%0d valid=%0b dout=0x%08h", digit_count, valid, dout);
    check("rst_calc_dout", dout, 32'd0);
    check("rst_calc_valid", {31'b0, valid}, 32'd0);
    check("rst_calc_count", {28'b0, digit_count}, 32'd0);
    repeat (20) @(negedge clk);
    check("rst_calc_no_event", {28'b0, digit_count}, 32'd0);
    press(4'b0001, 4'd4);
    check("post_rst_count", {28'b0, digit_count}, 32'd1);
    press(4'b0100, 4'd0);
    $display("txn post_reset_enter valid=%0b dout=0x%08h", valid, dout);
    check("post_rst_dout", dout, 32'd4);
    check("post_rst_valid", {31'b0, valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
